// File: rtl/bitwise_unit_pipe.sv
// Registered bitwise logic unit with a 2-entry in-order output buffer.
// Each result bit is looked up in a 4-entry truth table chosen by the opcode.
// out_data/out_zr/out_ng hold the head entry, and a second slot holds the queued result.
module bitwise_unit_pipe #(
   parameter int WIDTH = 16,
   parameter int CNT_W = 8
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic [2:0]       in_op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_zr,
   output logic             out_ng,
   output logic [CNT_W-1:0] xfer_count
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } occ_t;

   occ_t             occ;
   logic             valid_q;
   logic             accept_q;
   logic [3:0]       op_lut;
   logic [WIDTH-1:0] result;
   logic             result_zr;
   logic             result_ng;
   logic [WIDTH-1:0] slot_data;
   logic             slot_zr;
   logic             slot_ng;
   logic             push;
   logic             pop;

   // Truth table for the selected op, indexed by {a_bit, b_bit}.
   // NOT and PASS tables do not depend on b, so in_b is ignored for them.
   always_comb begin
      op_lut = 4'b0000;
      case (in_op)
         3'd0: op_lut = 4'b0011; // NOT a
         3'd1: op_lut = 4'b1000; // AND
         3'd2: op_lut = 4'b1110; // OR
         3'd3: op_lut = 4'b0110; // XOR
         3'd4: op_lut = 4'b0111; // NAND
         3'd5: op_lut = 4'b0001; // NOR
         3'd6: op_lut = 4'b1001; // XNOR
         3'd7: op_lut = 4'b1100; // PASS a
         default: op_lut = 4'b0000;
      endcase
   end

   for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
      assign result[gi] = op_lut[{in_a[gi], in_b[gi]}];
   end

   assign result_zr = (result == '0);
   assign result_ng = result[WIDTH-1];

   // in_ready comes from registered state only and is forced low during reset.
   assign in_ready  = reset_n & accept_q;
   assign out_valid = valid_q;
   assign push      = in_valid & in_ready;
   assign pop       = valid_q & out_ready;

   // Occupancy FSM with registered handshake outputs.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         occ      <= EMPTY;
         valid_q  <= 1'b0;
         accept_q <= 1'b1;
      end else begin
         case (occ)
            EMPTY: begin
               if (push) begin
                  occ     <= ONE;
                  valid_q <= 1'b1;
               end
            end
            ONE: begin
               if (push && !pop) begin
                  occ      <= FULL;
                  accept_q <= 1'b0;
               end else if (pop && !push) begin
                  occ     <= EMPTY;
                  valid_q <= 1'b0;
               end
            end
            FULL: begin
               if (pop) begin
                  occ      <= ONE;
                  accept_q <= 1'b1;
               end
            end
            default: begin
               occ      <= EMPTY;
               valid_q  <= 1'b0;
               accept_q <= 1'b1;
            end
         endcase
      end
   end

   // Buffer storage: the head drives the outputs and keeps the last popped value when empty.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         out_data  <= '0;
         out_zr    <= 1'b0;
         out_ng    <= 1'b0;
         slot_data <= '0;
         slot_zr   <= 1'b0;
         slot_ng   <= 1'b0;
      end else begin
         case (occ)
            EMPTY: begin
               if (push) begin
                  out_data <= result;
                  out_zr   <= result_zr;
                  out_ng   <= result_ng;
               end
            end
            ONE: begin
               if (push && pop) begin
                  out_data <= result;
                  out_zr   <= result_zr;
                  out_ng   <= result_ng;
               end else if (push) begin
                  slot_data <= result;
                  slot_zr   <= result_zr;
                  slot_ng   <= result_ng;
               end
            end
            FULL: begin
               if (pop) begin
                  out_data <= slot_data;
                  out_zr   <= slot_zr;
                  out_ng   <= slot_ng;
               end
            end
            default: ;
         endcase
      end
   end

   // Output transfer counter, wraps naturally at 2**CNT_W.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         xfer_count <= '0;
      end else if (pop) begin
         xfer_count <= xfer_count + 1'b1;
      end
   end

endmodule

// File: tb/tb_bitwise_unit_pipe.sv
// Scoreboard bench for bitwise_unit_pipe. A second instance with CNT_W=4 shares the
// stimulus so that the transfer counter wrap can be observed.
module tb_bitwise_unit_pipe;

   typedef struct packed {
      logic [15:0] data;
      logic        zr;
      logic        ng;
   } exp_t;

   logic        clock;
   logic        reset_n;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_a;
   logic [15:0] in_b;
   logic [2:0]  in_op;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_data;
   logic        out_zr;
   logic        out_ng;
   logic [7:0]  xfer_count;

   logic        s_in_ready;
   logic        s_out_valid;
   logic [15:0] s_out_data;
   logic        s_out_zr;
   logic        s_out_ng;
   logic [3:0]  s_xfer_count;

   exp_t q[$];
   int   total = 0;
   int   bad   = 0;
   int   xfers = 0;

   bitwise_unit_pipe #(.WIDTH(16), .CNT_W(8)) dut (
      .clock(clock), .reset_n(reset_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .in_op(in_op),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_zr(out_zr), .out_ng(out_ng),
      .xfer_count(xfer_count)
   );

   bitwise_unit_pipe #(.WIDTH(16), .CNT_W(4)) dut_small (
      .clock(clock), .reset_n(reset_n),
      .in_valid(in_valid), .in_ready(s_in_ready),
      .in_a(in_a), .in_b(in_b), .in_op(in_op),
      .out_valid(s_out_valid), .out_ready(out_ready),
      .out_data(s_out_data), .out_zr(s_out_zr), .out_ng(s_out_ng),
      .xfer_count(s_xfer_count)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, req, $time);
      end
   endtask

   function automatic logic [15:0] ref_op(input logic [15:0] a, input logic [15:0] b,
                                          input logic [2:0] op);
      case (op)
         3'd0: ref_op = ~a;
         3'd1: ref_op = a & b;
         3'd2: ref_op = a | b;
         3'd3: ref_op = a ^ b;
         3'd4: ref_op = ~(a & b);
         3'd5: ref_op = ~(a | b);
         3'd6: ref_op = ~(a ^ b);
         default: ref_op = a;
      endcase
   endfunction

   // Offer one operation; push its expected result at the accepting edge.
   task automatic send(input logic [15:0] a, input logic [15:0] b, input logic [2:0] op,
                       input logic [15:0] ed, input logic ez, input logic en);
      bit acc = 0;
      in_a = a; in_b = b; in_op = op; in_valid = 1'b1;
      for (int k = 0; k < 100 && !acc; k++) begin
         @(negedge clock);
         if (in_ready === 1'b1) acc = 1;
         @(posedge clock);
         if (acc) q.push_back(exp_t'({ed, ez, en}));
      end
      #1;
      in_valid = 1'b0;
      chk("accept", {31'd0, acc}, 32'd1);
   endtask

   // Wait until every expected result has been delivered.
   task automatic drain();
      for (int k = 0; k < 200 && q.size() != 0; k++) @(negedge clock);
      chk("drain", q.size(), 0);
      @(posedge clock);
      #1;
   endtask

   // Monitor: every output transfer is checked against the head of the scoreboard.
   initial begin
      exp_t e;
      forever begin
         @(negedge clock);
         if (reset_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (q.size() == 0) begin
               chk("unexpected_out", {16'd0, out_data}, 32'hFFFF_FFFF);
            end else begin
               e = q.pop_front();
               chk("out_data", {16'd0, out_data}, {16'd0, e.data});
               chk("out_zr", {31'd0, out_zr}, {31'd0, e.zr});
               chk("out_ng", {31'd0, out_ng}, {31'd0, e.ng});
               $display("xfer %0d: data=%h zr=%b ng=%b", xfers, out_data, out_zr, out_ng);
            end
            xfers++;
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] a;
      logic [15:0] b;
      logic [2:0]  op;

      reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      in_a = '0; in_b = '0; in_op = '0;

      // Reset hold and release
      repeat (3) @(posedge clock);
      #1;
      chk("rst_in_ready_low", {31'd0, in_ready}, 32'd0);
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      reset_n = 1'b1;
      #1;
      chk("rel_in_ready", {31'd0, in_ready}, 32'd1);
      chk("rel_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rel_out_data", {16'd0, out_data}, 32'd0);
      chk("rel_xfer", {24'd0, xfer_count}, 32'd0);
      @(posedge clock);
      #1;

      // Walking-one NOT, back to back
      out_ready = 1'b1;
      for (int i = 0; i < 16; i++) begin
         a = 16'h0001 << i;
         send(a, 16'h0000, 3'd0, ~a, 1'b0, (i < 15) ? 1'b1 : 1'b0);
      end
      drain();
      chk("walk_xfer", {24'd0, xfer_count}, 32'd16);
      chk("walk_hold_valid", {31'd0, out_valid}, 32'd0);
      chk("walk_hold_data", {16'd0, out_data}, 32'h7FFF);
      chk("small_xfer16", {28'd0, s_xfer_count}, 32'd0);

      // Zero result, also the 17th transfer for the 4-bit counter
      send(16'h00FF, 16'hFF00, 3'd1, 16'h0000, 1'b1, 1'b0);
      drain();
      chk("small_xfer17", {28'd0, s_xfer_count}, 32'd1);
      chk("xfer17", {24'd0, xfer_count}, 32'd17);

      // All ops on a fixed operand pair
      send(16'hF0F0, 16'hFF00, 3'd0, 16'h0F0F, 1'b0, 1'b0);
      send(16'hF0F0, 16'hFF00, 3'd1, 16'hF000, 1'b0, 1'b1);
      send(16'hF0F0, 16'hFF00, 3'd2, 16'hFFF0, 1'b0, 1'b1);
      send(16'hF0F0, 16'hFF00, 3'd3, 16'h0FF0, 1'b0, 1'b0);
      send(16'hF0F0, 16'hFF00, 3'd4, 16'h0FFF, 1'b0, 1'b0);
      send(16'hF0F0, 16'hFF00, 3'd5, 16'h000F, 1'b0, 1'b0);
      send(16'hF0F0, 16'hFF00, 3'd6, 16'hF00F, 1'b0, 1'b1);
      send(16'hF0F0, 16'hFF00, 3'd7, 16'hF0F0, 1'b0, 1'b1);
      drain();

      // Backpressure: two fill the buffer, the third waits
      out_ready = 1'b0;
      send(16'hF0F0, 16'hFF00, 3'd1, 16'hF000, 1'b0, 1'b1);
      send(16'hF0F0, 16'hFF00, 3'd2, 16'hFFF0, 1'b0, 1'b1);
      in_a = 16'hF0F0; in_b = 16'hFF00; in_op = 3'd3; in_valid = 1'b1;
      for (int k = 0; k < 2; k++) begin
         @(negedge clock);
         chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
         chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
         chk("bp_hold_data", {16'd0, out_data}, 32'hF000);
      end
      @(posedge clock);
      #1;
      out_ready = 1'b1;
      send(16'hF0F0, 16'hFF00, 3'd3, 16'h0FF0, 1'b0, 1'b0);
      drain();

      // Simultaneous push and pop while holding one entry
      out_ready = 1'b0;
      send(16'h1234, 16'h0000, 3'd7, 16'h1234, 1'b0, 1'b0);
      out_ready = 1'b1;
      for (int i = 0; i < 100; i++) begin
         a  = 16'($urandom);
         b  = 16'($urandom);
         op = 3'($urandom_range(0, 7));
         b  = ref_op(a, b, op);
         send(a, 16'(b ^ ref_op(a, b, op) ^ b), op, ref_op(a, 16'(b ^ ref_op(a, b, op) ^ b), op),
              (ref_op(a, 16'(b ^ ref_op(a, b, op) ^ b), op) == 16'h0000),
              ref_op(a, 16'(b ^ ref_op(a, b, op) ^ b), op) >> 15 == 16'd1);
         chk("sim_out_valid", {31'd0, out_valid}, 32'd1);
         chk("sim_in_ready", {31'd0, in_ready}, 32'd1);
      end
      drain();
      chk("sim_xfer", {24'd0, xfer_count}, 32'(xfers % 256));
      chk("sim_small_xfer", {28'd0, s_xfer_count}, 32'(xfers % 16));

      // Asynchronous reset mid-cycle with a full buffer
      out_ready = 1'b0;
      send(16'hAAAA, 16'h5555, 3'd2, 16'hFFFF, 1'b0, 1'b1);
      send(16'hAAAA, 16'h5555, 3'd3, 16'hFFFF, 1'b0, 1'b1);
      @(negedge clock);
      chk("full_in_ready", {31'd0, in_ready}, 32'd0);
      @(posedge clock);
      #3;
      reset_n = 1'b0;
      q.delete();
      xfers = 0;
      #1;
      chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("arst_in_ready", {31'd0, in_ready}, 32'd0);
      chk("arst_out_data", {16'd0, out_data}, 32'd0);
      chk("arst_xfer", {24'd0, xfer_count}, 32'd0);
      repeat (2) @(posedge clock);
      #1;
      reset_n = 1'b1;
      #1;
      chk("arel_in_ready", {31'd0, in_ready}, 32'd1);
      chk("arel_out_valid", {31'd0, out_valid}, 32'd0);

      // One transaction after reset
      out_ready = 1'b1;
      send(16'h0000, 16'h0000, 3'd0, 16'hFFFF, 1'b0, 1'b1);
      drain();
      chk("post_xfer", {24'd0, xfer_count}, 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
